mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 tb/tb_mult_div_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with a fixed-latency Busy window.
// Define MDU_MADD_EN to enable the MADD/MADDU multiply-accumulate ops.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MdOp,
  input  logic [31:0] DE_RD1,
  input  logic [31:0] DE_RD2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MLOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DLOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  logic          accept;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   q_s, r_s;
  logic [31:0]   q_u, r_u;
  logic [31:0]   nhi, nlo;
  logic          launch;
  logic [CW-1:0] nload;
  logic          mt_hi, mt_lo;

  assign Busy   = (state == RUN);
  assign accept = Start && (state == IDLE);

  assign prod_s = $signed({{32{DE_RD1[31]}}, DE_RD1}) *
                  $signed({{32{DE_RD2[31]}}, DE_RD2});
  assign prod_u = {32'd0, DE_RD1} * {32'd0, DE_RD2};

  // Zero divisor and INT_MIN/-1 are pinned explicitly, not left to '/'.
  always_comb begin
    q_s = 32'hFFFF_FFFF;
    r_s = DE_RD1;
    q_u = 32'hFFFF_FFFF;
    r_u = DE_RD1;
    if (DE_RD2 != 32'd0) begin
      q_u = DE_RD1 / DE_RD2;
      r_u = DE_RD1 % DE_RD2;
      if (DE_RD1 == 32'h8000_0000 && DE_RD2 == 32'hFFFF_FFFF) begin
        q_s = 32'h8000_0000;
        r_s = 32'd0;
      end else begin
        q_s = $signed(DE_RD1) / $signed(DE_RD2);
        r_s = $signed(DE_RD1) % $signed(DE_RD2);
      end
    end
  end

  always_comb begin
    nhi    = HI;
    nlo    = LO;
    launch = 1'b0;
    nload  = '0;
    mt_hi  = 1'b0;
    mt_lo  = 1'b0;
    case (MdOp)
      3'd0: begin
        {nhi, nlo} = prod_s;
        launch     = 1'b1;
        nload      = MLOAD;
      end
      3'd1: begin
        {nhi, nlo} = prod_u;
        launch     = 1'b1;
        nload      = MLOAD;
      end
      3'd2: begin
        {nhi, nlo} = {r_s, q_s};
        launch     = 1'b1;
        nload      = DLOAD;
      end
      3'd3: begin
        {nhi, nlo} = {r_u, q_u};
        launch     = 1'b1;
        nload      = DLOAD;
      end
      3'd4: mt_hi = 1'b1;
      3'd5: mt_lo = 1'b1;
`ifdef MDU_MADD_EN
      3'd6: begin
        {nhi, nlo} = {HI, LO} + prod_s;
        launch     = 1'b1;
        nload      = MLOAD;
      end
      3'd7: begin
        {nhi, nlo} = {HI, LO} + prod_u;
        launch     = 1'b1;
        nload      = MLOAD;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (mt_hi) HI <= DE_RD1;
            if (mt_lo) LO <= DE_RD1;
            if (launch) begin
              res_hi <= nhi;
              res_lo <= nlo;
              cnt    <= nload;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (cnt == '0) begin
            HI    <= res_hi;
            LO    <= res_lo;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an
// arithmetic HI/LO reference model.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MdOp;
  logic [31:0] DE_RD1;
  logic [31:0] DE_RD2;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MdOp(MdOp),
    .DE_RD1(DE_RD1), .DE_RD2(DE_RD2),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  function automatic void model(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] ehi,
    output logic [31:0] elo,
    output int          lat
  );
    longint sa, sb, ma, mb, q, r;
    logic [63:0] p;
    ehi = mhi;
    elo = mlo;
    lat = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p   = 64'(sa * sb);
    if (op == 3'd1 || op == 3'd7) p = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0, 3'd1: begin
        {ehi, elo} = p;
        lat = MC;
      end
      3'd2, 3'd3: begin
        lat = DC;
        if (b == 32'd0) begin
          elo = 32'hFFFF_FFFF;
          ehi = a;
        end else begin
          if (op == 3'd3) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q  = ((sa < 0) != (sb < 0)) ? -(ma / mb) : (ma / mb);
          r  = sa - q * sb;
          elo = q[31:0];
          ehi = r[31:0];
        end
      end
      3'd4: ehi = a;
      3'd5: elo = a;
      default: begin
`ifdef MDU_MADD_EN
        {ehi, elo} = {mhi, mlo} + p;
        lat = MC;
`endif
      end
    endcase
  endfunction

  // noise: 0 quiet, 1 random Start/ops while busy, 2 MTHI pulses while busy
  task automatic test_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int noise);
    logic [31:0] ehi, elo, ohi, olo;
    int lat;
    model(op, a, b, ehi, elo, lat);
    ohi = mhi;
    olo = mlo;
    Start  = 1'b1;
    MdOp   = op;
    DE_RD1 = a;
    DE_RD2 = b;
    @(negedge clk);
    for (int i = 0; i < lat; i++) begin
      Start = 1'b0;
      if (noise == 1) begin
        Start  = 1'($urandom);
        MdOp   = 3'($urandom);
        DE_RD1 = $urandom;
        DE_RD2 = $urandom;
      end else if (noise == 2) begin
        Start  = 1'b1;
        MdOp   = 3'd4;
        DE_RD1 = $urandom;
      end
      total++;
      if (Busy !== 1'b1 || HI !== ohi || LO !== olo) begin
        bad++;
        $display("FAIL busy_phase op=%0d cyc=%0d: Busy=%b HI=%h LO=%h, required Busy=1 HI=%h LO=%h",
                 op, i + 1, Busy, HI, LO, ohi, olo);
      end
      @(negedge clk);
    end
    Start = 1'b0;
    total++;
    if (Busy !== 1'b0 || HI !== ehi || LO !== elo) begin
      bad++;
      $display("FAIL result op=%0d a=%h b=%h: Busy=%b HI=%h LO=%h, required Busy=0 HI=%h LO=%h",
               op, a, b, Busy, HI, LO, ehi, elo);
    end
    mhi = ehi;
    mlo = elo;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    Start  = 1'b1;
    MdOp   = 3'd2;
    DE_RD1 = $urandom;
    DE_RD2 = $urandom;
    repeat (2) @(negedge clk);
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: Busy=%b, required 0", Busy);
    end
    total++;
    if (HI !== 32'd0) begin
      bad++;
      $display("FAIL reset_hi: HI=%h, required 0", HI);
    end
    total++;
    if (LO !== 32'd0) begin
      bad++;
      $display("FAIL reset_lo: LO=%h, required 0", LO);
    end
    reset = 1'b0;
    Start = 1'b0;
    @(negedge clk);
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_priority: Busy=%b, required 0", Busy);
    end
    mhi = 32'd0;
    mlo = 32'd0;
  endtask

  task automatic test_directed();
    test_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    test_op(3'd2, -32'sd7, 32'd2, 0);
    test_op(3'd3, 32'd7, 32'd0, 0);
    test_op(3'd2, 32'h1234_5678, 32'd0, 0);
    test_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
  endtask

  task automatic test_back_to_back();
    test_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    test_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    test_op(3'd4, 32'hCAFE_F00D, 32'd0, 0);
    test_op(3'd5, 32'h0BAD_BEEF, 32'd0, 0);
  endtask

  task automatic test_madd();
    test_op(3'd4, 32'd0, 32'd0, 0);
    test_op(3'd5, 32'hFFFF_FFFF, 32'd0, 0);
    test_op(3'd7, 32'd1, 32'd1, 0);
    test_op(3'd6, 32'hFFFF_FFF0, 32'd9, 1);
  endtask

  task automatic test_reset_abort();
    test_op(3'd4, 32'h5555_AAAA, 32'd0, 0);
    Start  = 1'b1;
    MdOp   = 3'd2;
    DE_RD1 = -32'sd7;
    DE_RD2 = 32'd2;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL abort_now: Busy=%b HI=%h LO=%h, required Busy=0 HI=0 LO=0",
               Busy, HI, LO);
    end
    repeat (DC + 2) @(negedge clk);
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL abort_later: Busy=%b HI=%h LO=%h, required Busy=0 HI=0 LO=0",
               Busy, HI, LO);
    end
    mhi = 32'd0;
    mlo = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'd1 + 32'($urandom_range(0, 6));
      test_op(3'($urandom), a, b, int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset  = 1'b1;
    Start  = 1'b0;
    MdOp   = 3'd0;
    DE_RD1 = 32'd0;
    DE_RD2 = 32'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_madd();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
